camera_fifo_burst_ctrl: RTL

//  Read-side scheduler for the camera FIFO (async, 16-bit data, 4096 deep, no output register).

---
 rtl/camera_fifo_burst_ctrl_if.sv | 36 +++
 rtl/camera_fifo_burst_ctrl.sv | 81 ++++++++
 2 files changed

// File: rtl/camera_fifo_burst_ctrl_if.sv
// camera_fifo_burst_ctrl_if: camera FIFO read port, write-side monitor taps and memory write channel
interface camera_fifo_burst_ctrl_if #(
   parameter int DATA_W  = 16,
   parameter int LEVEL_W = 13,
   parameter int ADDR_W  = 28
);
   logic [LEVEL_W-1:0] fifo_rd_water_level;
   logic               fifo_rd_empty;
   logic [DATA_W-1:0]  fifo_rd_data;
   logic               fifo_rd_en;
   logic               fifo_wr_en;
   logic               fifo_wr_full;
   logic               frame_start;
   logic               mem_req;
   logic               mem_gnt;
   logic [ADDR_W-1:0]  mem_addr;
   logic [DATA_W-1:0]  mem_wdata;
   logic               mem_wvalid;
   logic               mem_wlast;
   logic               frame_done;
   logic               busy;
   logic [7:0]         ovf_cnt;
   logic               underflow_err;
   modport master (
      input  fifo_rd_water_level, fifo_rd_empty, fifo_rd_data, fifo_wr_en, fifo_wr_full,
             frame_start, mem_gnt,
      output fifo_rd_en, mem_req, mem_addr, mem_wdata, mem_wvalid, mem_wlast, frame_done,
             busy, ovf_cnt, underflow_err
   );
   modport slave (
      output fifo_rd_water_level, fifo_rd_empty, fifo_rd_data, fifo_wr_en, fifo_wr_full,
             frame_start, mem_gnt,
      input  fifo_rd_en, mem_req, mem_addr, mem_wdata, mem_wvalid, mem_wlast, frame_done,
             busy, ovf_cnt, underflow_err
   );
endinterface

// File: rtl/camera_fifo_burst_ctrl.sv
// camera_fifo_burst_ctrl: drains the camera FIFO in fixed bursts into frame-relative memory addresses
module camera_fifo_burst_ctrl #(
   parameter int                DATA_W       = 16,
   parameter int                LEVEL_W      = 13,
   parameter int                BURST_LEN    = 64,
   parameter int                ADDR_W       = 28,
   parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
   parameter int                FRAME_BURSTS = 14400
) (
   input logic                      clk,
   input logic                      tb_rst,
   camera_fifo_burst_ctrl_if.master bus
);
   localparam int BW = $clog2(BURST_LEN);
   localparam int IW = $clog2(FRAME_BURSTS + 1);
   localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, BURST = 2'd2, DRAIN = 2'd3;
   logic [1:0]    state;
   logic [BW-1:0] beat, beat_d;
   logic [IW-1:0] burst_idx;
   logic          rd_en_d, pend;
   logic          last_beat, wrap, resync;
   assign last_beat = beat == BW'(BURST_LEN - 1);
   assign wrap = burst_idx == IW'(FRAME_BURSTS - 1);
   assign resync = pend | bus.frame_start;
   assign bus.fifo_rd_en = state == BURST;
   assign bus.mem_req = state == REQ;
   assign bus.busy = state != IDLE;
   assign bus.mem_wvalid = rd_en_d;
   // FIFO has no output register, so read data lines up with the delayed read strobe
   assign bus.mem_wdata = rd_en_d ? bus.fifo_rd_data : DATA_W'(0);
   assign bus.mem_wlast = rd_en_d && beat_d == BW'(BURST_LEN - 1);
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         state <= IDLE;
         beat <= '0;
         beat_d <= '0;
         rd_en_d <= 1'b0;
         burst_idx <= '0;
         pend <= 1'b0;
         bus.mem_addr <= BASE_ADDR;
         bus.frame_done <= 1'b0;
         bus.ovf_cnt <= '0;
         bus.underflow_err <= 1'b0;
      end else begin
         rd_en_d <= state == BURST;
         beat_d <= beat;
         bus.frame_done <= 1'b0;
         if (bus.fifo_wr_en && bus.fifo_wr_full && bus.ovf_cnt != 8'hFF)
            bus.ovf_cnt <= bus.ovf_cnt + 8'd1;
         if (state == BURST && bus.fifo_rd_empty)
            bus.underflow_err <= 1'b1;
         if (bus.frame_start && state != IDLE)
            pend <= 1'b1;
         case (state)
            IDLE:
               if (bus.frame_start) begin
                  bus.mem_addr <= BASE_ADDR;
                  burst_idx <= '0;
               end else if (bus.fifo_rd_water_level >= LEVEL_W'(BURST_LEN))
                  state <= REQ;
            REQ:
               if (bus.mem_gnt) begin
                  state <= BURST;
                  beat <= '0;
               end
            BURST: begin
               beat <= beat + 1'b1;
               state <= last_beat ? DRAIN : BURST;
            end
            default: begin
               // a frame_start seen during the burst overrides the normal advance/wrap
               state <= IDLE;
               pend <= 1'b0;
               bus.mem_addr <= resync || wrap ? BASE_ADDR : bus.mem_addr + ADDR_W'(BURST_LEN);
               burst_idx <= resync || wrap ? '0 : burst_idx + 1'b1;
               bus.frame_done <= !resync && wrap;
            end
         endcase
      end
   end
endmodule
